// File: rtl/fmul_sig_iter.sv
// fmul_sig_iter: sequential radix-2 shift-add significand multiplier.
// Forms the full 2*MANT_W-bit product one multiplier bit per clock, then
// normalizes and rounds to nearest-even and presents the mantissa together
// with normalization / rounding-carry flags on a valid/ready handshake.
module fmul_sig_iter #(
  parameter int MANT_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] sig_a,
  input  logic [MANT_W-1:0] sig_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant,
  output logic              norm_shift,
  output logic              rnd_carry,
  output logic              inexact,
  output logic              zero
);

  localparam int PW = 2 * MANT_W;
  localparam int CW = $clog2(MANT_W + 1);
  localparam logic [CW-1:0] LAST = CW'(MANT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ROUND, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_in_ready_nxt;
  logic              w_out_valid_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [MANT_W-1:0] r_mcand;
  logic [MANT_W-1:0] r_mplier;
  logic [PW-1:0]     r_p;
  logic [CW-1:0]     r_count;
  logic [MANT_W-1:0] r_mant;
  logic              r_norm;
  logic              r_carry;
  logic              r_inexact;
  logic              r_zero;

  // Normalize and round-to-nearest-even the raw product.
  // Result packing: {mant, norm_shift, rnd_carry, inexact, zero}.
  function automatic logic [MANT_W+3:0] round_rne(input logic [PW-1:0] p);
    logic [MANT_W-1:0] top;
    logic              guard;
    logic              sticky;
    logic              norm;
    logic              inc;
    logic [MANT_W:0]   sum;
    logic              carry;
    logic [MANT_W-1:0] m;
    norm = p[PW-1];
    if (norm) begin
      top    = p[PW-1:MANT_W];
      guard  = p[MANT_W-1];
      sticky = |p[MANT_W-2:0];
    end else begin
      top    = p[PW-2:MANT_W-1];
      guard  = p[MANT_W-2];
      sticky = |p[MANT_W-3:0];
    end
    inc   = guard & (sticky | top[0]);
    sum   = {1'b0, top} + {{MANT_W{1'b0}}, inc};
    carry = sum[MANT_W];
    // A carry out of the mantissa means top was all ones: result is 1.000...
    m     = carry ? {1'b1, {(MANT_W-1){1'b0}}} : sum[MANT_W-1:0];
    if (p == '0)
      return {{MANT_W{1'b0}}, 4'b0001};
    return {m, norm, carry, guard | sticky, 1'b0};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid && r_in_ready) w_state_nxt = S_MUL;
      S_MUL:   if (r_count == LAST)        w_state_nxt = S_ROUND;
      S_ROUND:                             w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)              w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs for the upcoming state (registered below)
  always_comb begin
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  // Register the handshake outputs so no input reaches an output combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Operand latch, shift-add accumulation and rounded result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_p       <= '0;
      r_count   <= '0;
      r_mant    <= '0;
      r_norm    <= 1'b0;
      r_carry   <= 1'b0;
      r_inexact <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mcand  <= sig_a;
            r_mplier <= sig_b;
            r_p      <= '0;
            r_count  <= '0;
          end
        end
        S_MUL: begin
          if (r_mplier[0])
            r_p <= r_p + ({{MANT_W{1'b0}}, r_mcand} << r_count);
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
        end
        S_ROUND: begin
          {r_mant, r_norm, r_carry, r_inexact, r_zero} <= round_rne(r_p);
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign mant       = r_mant;
  assign norm_shift = r_norm;
  assign rnd_carry  = r_carry;
  assign inexact    = r_inexact;
  assign zero       = r_zero;

endmodule

// File: tb/tb_fmul_sig_iter.sv
// Directed and random bench for fmul_sig_iter.
module tb_fmul_sig_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] sig_a;
  logic [23:0] sig_b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] mant;
  logic        norm_shift;
  logic        rnd_carry;
  logic        inexact;
  logic        zero;

  int n_vec = 0;
  int n_bad = 0;

  fmul_sig_iter #(.MANT_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sig_a      (sig_a),
    .sig_b      (sig_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant       (mant),
    .norm_shift (norm_shift),
    .rnd_carry  (rnd_carry),
    .inexact    (inexact),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  // Directed vectors: operands, expected mantissa, expected {norm,carry,inexact,zero}
  localparam logic [23:0] VA [7] = '{24'h800000, 24'hC00000, 24'h800001, 24'h800001,
                                     24'h000000, 24'hE12000, 24'hFFFFFF};
  localparam logic [23:0] VB [7] = '{24'h800000, 24'hC00000, 24'hC00000, 24'h800001,
                                     24'hFFFFFF, 24'h918E00, 24'hFFFFFF};
  localparam logic [23:0] VM [7] = '{24'h800000, 24'h900000, 24'hC00002, 24'h800002,
                                     24'h000000, 24'h800000, 24'hFFFFFE};
  localparam logic [3:0]  VF [7] = '{4'b0000, 4'b1000, 4'b0010, 4'b0010,
                                     4'b0001, 4'b0110, 4'b1010};

  // Independent reference: exact product, then round-half-even on the remainder
  function automatic logic [27:0] ref_model(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] p;
    logic [47:0] q;
    logic [47:0] rem;
    logic [47:0] half;
    int          sh;
    logic        nrm;
    logic        cy;
    logic        inx;
    p = {24'd0, a} * {24'd0, b};
    if (p == 48'd0) return {24'h0, 4'b0001};
    nrm  = p[47];
    sh   = nrm ? 24 : 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 48'd1 << (sh - 1);
    inx  = (rem != 48'd0);
    if (rem > half || (rem == half && q[0])) q = q + 48'd1;
    cy = (q == 48'h1000000);
    if (cy) q = 48'h800000;
    return {q[23:0], nrm, cy, inx, 1'b0};
  endfunction

  // Present operands until accepted, scramble them afterwards, count clocks to out_valid
  task automatic do_op(input logic [23:0] a, input logic [23:0] b, output int lat);
    int wait_c;
    lat = -1;
    wait_c = 0;
    while (!in_ready && wait_c < 50) begin
      @(posedge clk); #1;
      wait_c++;
    end
    sig_a = a;
    sig_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sig_a = ~a;
    sig_b = b ^ 24'h5A5A5A;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sig_a = '0;
    sig_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_hs: in_ready/out_valid=%b required 10", {in_ready, out_valid});
    end
    n_vec++;
    if ({mant, norm_shift, rnd_carry, inexact, zero} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_out: mant=%h flags=%b required 000000/0000", mant,
               {norm_shift, rnd_carry, inexact, zero});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(VA[i], VB[i], lat);
      n_vec++;
      if (lat != 25) begin
        n_bad++;
        $display("FAIL dir%0d_latency: got %0d required 25", i, lat);
      end
      n_vec++;
      if (mant !== VM[i]) begin
        n_bad++;
        $display("FAIL dir%0d_mant: got %h required %h", i, mant, VM[i]);
      end
      n_vec++;
      if ({norm_shift, rnd_carry, inexact, zero} !== VF[i]) begin
        n_bad++;
        $display("FAIL dir%0d_flags: got %b required %b", i,
                 {norm_shift, rnd_carry, inexact, zero}, VF[i]);
      end
      release_out();
      n_vec++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_bad++;
        $display("FAIL dir%0d_release: out_valid/in_ready=%b required 01", i,
                 {out_valid, in_ready});
      end
    end
  endtask

  task automatic test_stall();
    int lat;
    logic seen;
    do_op(24'hC00000, 24'hC00000, lat);
    n_vec++;
    if (lat != 25) begin
      n_bad++;
      $display("FAIL stall_latency: got %0d required 25", lat);
    end
    sig_a = 24'h123456;
    sig_b = 24'hABCDEF;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready, mant, norm_shift, rnd_carry, inexact, zero} !==
          {1'b1, 1'b0, 24'h900000, 4'b1000}) begin
        n_bad++;
        $display("FAIL stall_hold%0d: v/r=%b mant=%h flags=%b required 10/900000/1000", c,
                 {out_valid, in_ready}, mant, {norm_shift, rnd_carry, inexact, zero});
      end
    end
    in_valid = 1'b0;
    release_out();
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_ignored_req: activity seen=%b required 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    sig_a = 24'hFFFFFF;
    sig_b = 24'hFFFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, out_valid, mant, norm_shift, rnd_carry, inexact, zero} !==
        {1'b1, 1'b0, 24'h0, 4'b0000}) begin
      n_bad++;
      $display("FAIL midreset_state: r/v=%b mant=%h flags=%b required 10/000000/0000",
               {in_ready, out_valid}, mant, {norm_shift, rnd_carry, inexact, zero});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_no_valid: out_valid seen=%b required 0", seen);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_idle_out_ready();
    logic seen;
    seen = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    out_ready = 1'b0;
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_out_ready: activity seen=%b required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(24'h800000, 24'h800000, lat);
    sig_a = 24'h800001;
    sig_b = 24'hC00000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_release: out_valid/in_ready=%b required 01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept: in_ready=%b required 0", in_ready);
    end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    n_vec++;
    if (lat != 25 || mant !== 24'hC00002) begin
      n_bad++;
      $display("FAIL b2b_result: latency=%0d mant=%h required 25/c00002", lat, mant);
    end
    release_out();
  endtask

  task automatic test_random();
    int          lat;
    logic [23:0] a;
    logic [23:0] b;
    logic [27:0] exp_r;
    for (int i = 0; i < 1000; i++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      if (i % 8 != 0) begin
        a[23] = 1'b1;
        b[23] = 1'b1;
      end
      exp_r = ref_model(a, b);
      do_op(a, b, lat);
      n_vec++;
      if (lat != 25) begin
        n_bad++;
        $display("FAIL rand%0d_latency: got %0d required 25", i, lat);
      end
      n_vec++;
      if ({mant, norm_shift, rnd_carry, inexact, zero} !== exp_r) begin
        n_bad++;
        $display("FAIL rand%0d_result a=%h b=%h: got %h/%b required %h/%b", i, a, b,
                 mant, {norm_shift, rnd_carry, inexact, zero}, exp_r[27:4], exp_r[3:0]);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_idle_out_ready();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
